qk_tile_sram: RTL

//  Dual-bank (Q, K) row memory serving the attention score engine's read interface.

---
 rtl/qk_tile_sram.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/qk_tile_sram.sv
// rtl/qk_tile_sram.sv - dual-bank Q/K row SRAM with pipelined reads and a 32-bit word-stream load port
// Optional: define QK_SRAM_PARITY_EN to store per-lane even parity and flag read mismatches on rd_par_err.
module qk_tile_sram #(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(DEPTH)-1:0]   Q_mem_addr,
  input  logic [$clog2(DEPTH)-1:0]   K_mem_addr,
  output logic [127:0]               Q_mem_out,
  output logic [127:0]               K_mem_out,
  input  logic                       rd_lock,
  input  logic                       ld_start,
  input  logic                       ld_bank,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [31:0]                ld_data,
  output logic                       ld_busy,
  output logic                       ld_done,
  output logic                       rd_par_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {L_IDLE, L_FILL, L_COMMIT} ld_state_e;

  ld_state_e                   state_q, state_d;
  logic [1:0]                  lane_cnt_q, lane_cnt_d;
  logic [AW-1:0]               row_ptr_q, row_ptr_d;
  logic                        bank_q, bank_d;
  logic [3:0][31:0]            lane_buf_q, lane_buf_d;
  logic                        ld_done_q, ld_done_d;
  logic [READ_LAT-1:0][AW-1:0] q_pipe_q, q_pipe_d;
  logic [READ_LAT-1:0][AW-1:0] k_pipe_q, k_pipe_d;
  logic [127:0]                q_out_q, q_out_d;
  logic [127:0]                k_out_q, k_out_d;
  logic                        par_err_q, par_err_d;
  logic                        accept;
  logic                        commit;

  logic [127:0] q_mem [DEPTH];
  logic [127:0] k_mem [DEPTH];

  assign ld_ready = (state_q == L_FILL) && !rd_lock;
  assign accept   = ld_ready && ld_valid;
  assign commit   = (state_q == L_COMMIT);

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    row_ptr_d  = row_ptr_q;
    bank_d     = bank_q;
    lane_buf_d = lane_buf_q;
    ld_done_d  = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (ld_start) begin
          bank_d     = ld_bank;
          row_ptr_d  = '0;
          lane_cnt_d = '0;
          state_d    = L_FILL;
        end
      end
      L_FILL: begin
        if (accept) begin
          lane_buf_d[lane_cnt_q] = ld_data;
          lane_cnt_d             = lane_cnt_q + 2'd1;
          if (lane_cnt_q == 2'd3) state_d = L_COMMIT;
        end
      end
      L_COMMIT: begin
        lane_cnt_d = '0;
        // row_ptr saturates on the last row; a fresh ld_start is needed to reload
        if (row_ptr_q == AW'(DEPTH - 1)) begin
          ld_done_d = 1'b1;
          state_d   = L_IDLE;
        end else begin
          row_ptr_d = row_ptr_q + AW'(1);
          state_d   = L_FILL;
        end
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_comb begin
    q_pipe_d[0] = Q_mem_addr;
    k_pipe_d[0] = K_mem_addr;
    for (int i = 1; i < READ_LAT; i++) begin
      q_pipe_d[i] = q_pipe_q[i-1];
      k_pipe_d[i] = k_pipe_q[i-1];
    end
    // sampled on the commit edge itself, so a colliding read returns the old row
    q_out_d = q_mem[q_pipe_q[READ_LAT-1]];
    k_out_d = k_mem[k_pipe_q[READ_LAT-1]];
  end

  always_ff @(posedge clk) begin
    if (commit && !bank_q) q_mem[row_ptr_q] <= lane_buf_q;
    if (commit && bank_q)  k_mem[row_ptr_q] <= lane_buf_q;
  end

`ifdef QK_SRAM_PARITY_EN
  logic [3:0] q_par [DEPTH];
  logic [3:0] k_par [DEPTH];

  function automatic logic [3:0] lane_par(input logic [127:0] row);
    logic [3:0] p;
    for (int n = 0; n < 4; n++) p[n] = ^row[32*n +: 32];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (commit && !bank_q) q_par[row_ptr_q] <= lane_par(lane_buf_q);
    if (commit && bank_q)  k_par[row_ptr_q] <= lane_par(lane_buf_q);
  end

  always_comb begin
    par_err_d = (lane_par(q_mem[q_pipe_q[READ_LAT-1]]) != q_par[q_pipe_q[READ_LAT-1]]) ||
                (lane_par(k_mem[k_pipe_q[READ_LAT-1]]) != k_par[k_pipe_q[READ_LAT-1]]);
  end
`else
  always_comb par_err_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= L_IDLE;
      lane_cnt_q <= '0;
      row_ptr_q  <= '0;
      bank_q     <= 1'b0;
      lane_buf_q <= '0;
      ld_done_q  <= 1'b0;
      q_pipe_q   <= '0;
      k_pipe_q   <= '0;
      q_out_q    <= '0;
      k_out_q    <= '0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      row_ptr_q  <= row_ptr_d;
      bank_q     <= bank_d;
      lane_buf_q <= lane_buf_d;
      ld_done_q  <= ld_done_d;
      q_pipe_q   <= q_pipe_d;
      k_pipe_q   <= k_pipe_d;
      q_out_q    <= q_out_d;
      k_out_q    <= k_out_d;
      par_err_q  <= par_err_d;
    end
  end

  assign Q_mem_out  = q_out_q;
  assign K_mem_out  = k_out_q;
  assign ld_busy    = (state_q != L_IDLE);
  assign ld_done    = ld_done_q;
  assign rd_par_err = par_err_q;
endmodule
